// File: rtl/ioctl_upload_ctrl_if.sv
// SDRAM toggle req/ack read port used by the ioctl upload controller.
// master: controller (drives mem_req/mem_a); slave: SDRAM port (drives mem_ack/mem_q).
interface ioctl_upload_ctrl_if;
   logic        mem_req;
   logic        mem_ack;
   logic [22:0] mem_a;
   logic [15:0] mem_q;

   modport master (
      output mem_req,
      output mem_a,
      input  mem_ack,
      input  mem_q
   );

   modport slave (
      input  mem_req,
      input  mem_a,
      output mem_ack,
      output mem_q
   );
endinterface

// File: rtl/ioctl_upload_ctrl.sv
// Core-to-host ioctl upload: fetches 16-bit SDRAM words over a toggle
// req/ack port and presents one byte per host read on ioctl_din.
// Ports: clk_sys, reset_n (async, active low); ioctl_upload/index/rd/addr
// from data_io; ioctl_din to data_io; mem (SDRAM port, master side);
// busy (fetch outstanding), overrun (sticky dropped read), checksum.
// Optional: UPLOAD_CHECKSUM_EN builds the running byte-sum adder;
// otherwise checksum is tied to 8'h00.
module ioctl_upload_ctrl #(
   parameter logic [7:0]  INDEX = 8'h04,
   parameter logic [22:0] BASE  = 23'h0,
   parameter logic [16:0] LEN   = 17'h01000,
   parameter logic [7:0]  FILL  = 8'hFF
) (
   input  logic                       clk_sys,
   input  logic                       reset_n,
   input  logic                       ioctl_upload,
   input  logic [7:0]                 ioctl_index,
   input  logic                       ioctl_rd,
   input  logic [24:0]                ioctl_addr,
   output logic [7:0]                 ioctl_din,
   ioctl_upload_ctrl_if.master        mem,
   output logic                       busy,
   output logic                       overrun,
   output logic [7:0]                 checksum
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_READY = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [7:0]  din_q, din_d;
   logic        req_q, req_d;
   logic [22:0] a_q, a_d;
   logic        busy_q, busy_d;
   logic        ovr_q, ovr_d;
   logic [16:0] off_q, off_d;
   logic        cval_q, cval_d;
   logic [15:0] ctag_q, ctag_d;
   logic [15:0] cword_q, cword_d;
   logic        upl_q;
   logic        pend_q, pend_d;

   logic [16:0] nxt;
   logic        ack_ok;
   logic        rise;
   logic        start;
   logic        rd_acc;
   logic        fetch_go;

   // Offsets are 17 bits wide; upper host address bits are don't-care.
   logic unused_addr;
   assign unused_addr = ^ioctl_addr[24:17];

   assign nxt    = ioctl_addr[16:0] + 17'd1;
   assign ack_ok = (mem.mem_ack == req_q);
   assign rise   = ioctl_upload & ~upl_q;
   // pend_q remembers a rise that happened while draining, so it can
   // still start the upload once the FSM is back in IDLE.
   assign start  = (state_q == S_IDLE) && ioctl_upload &&
                   (ioctl_index == INDEX) && (rise || pend_q);
   assign rd_acc = (state_q == S_READY) && ioctl_upload && ioctl_rd;

   always_comb begin
      state_d  = state_q;
      din_d    = din_q;
      req_d    = req_q;
      a_d      = a_q;
      busy_d   = busy_q;
      ovr_d    = ovr_q;
      off_d    = off_q;
      cval_d   = cval_q;
      ctag_d   = ctag_q;
      cword_d  = cword_q;
      pend_d   = pend_q;
      fetch_go = 1'b0;

      if (!ioctl_upload) begin
         pend_d = 1'b0;
      end else if (rise && state_q != S_IDLE) begin
         pend_d = 1'b1;
      end

      if (ioctl_rd && busy_q) begin
         ovr_d = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               ovr_d    = 1'b0;
               off_d    = 17'd0;
               pend_d   = 1'b0;
               fetch_go = 1'b1;
            end
         end
         S_FETCH: begin
            if (!ioctl_upload) begin
               cval_d = 1'b0;
               if (ack_ok) begin
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DRAIN;
               end
            end else if (ack_ok) begin
               cword_d = mem.mem_q;
               ctag_d  = off_q[16:1];
               cval_d  = 1'b1;
               din_d   = off_q[0] ? mem.mem_q[15:8] : mem.mem_q[7:0];
               busy_d  = 1'b0;
               state_d = S_READY;
            end
         end
         S_READY: begin
            if (!ioctl_upload) begin
               cval_d  = 1'b0;
               state_d = S_IDLE;
            end else if (ioctl_rd) begin
               off_d = nxt;
               if (nxt >= LEN) begin
                  din_d = FILL;
               end else if (cval_q && ctag_q == nxt[16:1]) begin
                  din_d = nxt[0] ? cword_q[15:8] : cword_q[7:0];
               end else begin
                  fetch_go = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (ack_ok) begin
               busy_d  = 1'b0;
               cval_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (fetch_go) begin
         state_d = S_FETCH;
         a_d     = BASE + {7'd0, off_d[16:1]};
         req_d   = ~req_q;
         busy_d  = 1'b1;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         din_q   <= 8'h00;
         req_q   <= 1'b0;
         a_q     <= 23'h0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
         off_q   <= 17'h0;
         cval_q  <= 1'b0;
         ctag_q  <= 16'h0;
         cword_q <= 16'h0;
         upl_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         din_q   <= din_d;
         req_q   <= req_d;
         a_q     <= a_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
         off_q   <= off_d;
         cval_q  <= cval_d;
         ctag_q  <= ctag_d;
         cword_q <= cword_d;
         upl_q   <= ioctl_upload;
         pend_q  <= pend_d;
      end
   end

`ifdef UPLOAD_CHECKSUM_EN
   logic [7:0] cks_q, cks_d;

   always_comb begin
      cks_d = cks_q;
      if (start) begin
         cks_d = 8'h00;
      end else if (rd_acc) begin
         cks_d = cks_q + din_q;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         cks_q <= 8'h00;
      end else begin
         cks_q <= cks_d;
      end
   end

   assign checksum = cks_q;
`else
   logic unused_cks;
   assign unused_cks = rd_acc;
   assign checksum   = 8'h00;
`endif

   assign ioctl_din   = din_q;
   assign mem.mem_req = req_q;
   assign mem.mem_a   = a_q;
   assign busy        = busy_q;
   assign overrun     = ovr_q;

endmodule

// File: tb/tb_ioctl_upload_ctrl.sv
// Bench for ioctl_upload_ctrl: directed scenarios plus random host reads
// against a byte-level model of the upload stream.
module tb_ioctl_upload_ctrl;

   localparam logic [22:0] BASE = 23'h012340;
   localparam logic [16:0] LEN  = 17'd4;
   localparam logic [7:0]  FILL = 8'hFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        upload;
   logic [7:0]  index;
   logic        rd;
   logic [24:0] addr;
   logic [7:0]  din;
   logic        busy;
   logic        overrun;
   logic [7:0]  checksum;

   ioctl_upload_ctrl_if mif ();

   ioctl_upload_ctrl #(
      .INDEX (8'h04),
      .BASE  (BASE),
      .LEN   (LEN),
      .FILL  (FILL)
   ) dut (
      .clk_sys      (clk),
      .reset_n      (rst_n),
      .ioctl_upload (upload),
      .ioctl_index  (index),
      .ioctl_rd     (rd),
      .ioctl_addr   (addr),
      .ioctl_din    (din),
      .mem          (mif),
      .busy         (busy),
      .overrun      (overrun),
      .checksum     (checksum)
   );

   always #5 clk = ~clk;

   // SDRAM port: answers after lat extra cycles unless stalled.
   logic [15:0] words [4];
   int          lat = 0;
   bit          stall = 0;
   int          cnt;
   logic [22:0] woff;
   assign woff = mif.mem_a - BASE;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mif.mem_ack <= 1'b0;
         mif.mem_q   <= 16'h0;
         cnt         <= 0;
      end else if (mif.mem_req != mif.mem_ack && !stall) begin
         if (cnt >= lat) begin
            mif.mem_ack <= mif.mem_req;
            mif.mem_q   <= words[woff[1:0]];
            cnt         <= 0;
         end else begin
            cnt <= cnt + 1;
         end
      end
   end

   int ntog = 0;
   always @(mif.mem_req) ntog++;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   // Model of the upload stream.
   int         m_off;
   int         m_tag;
   logic [7:0] m_din;
   logic [7:0] m_cks;
   int         m_tog;
   bit         m_ovr;
   bit         m_fetch;

   function automatic logic [7:0] byte_at(input int off);
      logic [15:0] w;
      if (off >= int'(LEN)) return FILL;
      w = words[(off >> 1) & 3];
      return (off & 1) ? w[15:8] : w[7:0];
   endfunction

   function automatic logic [7:0] exp_cks();
`ifdef UPLOAD_CHECKSUM_EN
      return m_cks;
`else
      return 8'h00;
`endif
   endfunction

   task automatic model_start();
      m_tog++;
      m_tag = 0;
      m_off = 0;
      m_cks = 8'h00;
      m_ovr = 0;
      m_din = byte_at(0);
   endtask

   task automatic model_rd(input int a);
      int nxt;
      nxt     = (a + 1) & 'h1FFFF;
      m_cks   = m_cks + m_din;
      m_off   = nxt;
      m_fetch = 0;
      if (nxt < int'(LEN) && (nxt >> 1) != m_tag) begin
         m_tog++;
         m_tag   = nxt >> 1;
         m_fetch = 1;
      end
      m_din = byte_at(nxt);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && busy; i++) @(negedge clk);
      if (busy) check("timeout_busy", busy, 1'b0);
   endtask

   task automatic up_start(input logic [7:0] idx);
      @(negedge clk);
      index  = idx;
      upload = 1'b1;
      @(negedge clk);
      wait_idle();
   endtask

   task automatic host_rd(input int a);
      model_rd(a);
      @(negedge clk);
      rd   = 1'b1;
      addr = 25'(a);
      @(negedge clk);
      rd = 1'b0;
      wait_idle();
      check("rd_din", din, m_din);
      check("rd_tog", ntog, m_tog);
      check("rd_cks", checksum, exp_cks());
      if (m_fetch) check("rd_mem_a", mif.mem_a, BASE + 23'(m_tag));
   endtask

   initial begin
      rst_n  = 1'b0;
      upload = 1'b0;
      index  = 8'h00;
      rd     = 1'b0;
      addr   = 25'h0;
      words[0] = 16'hA55A;
      words[1] = 16'h2010;
      words[2] = 16'h0000;
      words[3] = 16'h0000;
      m_tog = 0;
      m_tag = -1;
      m_ovr = 0;
      m_cks = 8'h00;
      m_din = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_din", din, 8'h00);
      check("rst_req", mif.mem_req, 1'b0);
      check("rst_a", mif.mem_a, 23'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_ovr", overrun, 1'b0);
      check("rst_cks", checksum, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);
      ntog = 0;

      // First fetch and the directed byte sequence.
      lat = 2;
      model_start();
      up_start(8'h04);
      check("start_tog", ntog, m_tog);
      check("start_a", mif.mem_a, BASE);
      check("start_din", din, 8'h5A);
      host_rd(0);
      check("hit_din", din, 8'hA5);
      host_rd(1);
      host_rd(2);
      host_rd(3);
      check("end_fill", din, FILL);
`ifdef UPLOAD_CHECKSUM_EN
      check("cks_2f", checksum, 8'h2F);
`else
      check("cks_off", checksum, 8'h00);
`endif
      host_rd(4);
      host_rd('h1FFFF);

      // Read while a fetch is stalled.
      stall = 1;
      model_rd(1);
      m_ovr = 1;
      @(negedge clk); rd = 1'b1; addr = 25'd1;
      @(negedge clk); rd = 1'b0;
      @(negedge clk); rd = 1'b1; addr = 25'd5;
      @(negedge clk); rd = 1'b0;
      check("ovr_set", overrun, m_ovr);
      check("ovr_busy", busy, 1'b1);
      stall = 0;
      wait_idle();
      check("ovr_din", din, m_din);
      check("ovr_tog", ntog, m_tog);
      check("ovr_hold", overrun, m_ovr);

      // Abort mid-fetch, then restart while draining.
      stall = 1;
      model_rd(0);
      @(negedge clk); rd = 1'b1; addr = 25'd0;
      @(negedge clk); rd = 1'b0; upload = 1'b0;
      repeat (3) @(negedge clk);
      check("drain_busy", busy, 1'b1);
      upload = 1'b1;
      index  = 8'h04;
      repeat (2) @(negedge clk);
      check("drain_hold", ntog, m_tog);
      stall = 0;
      for (int i = 0; i < 50 && ntog == m_tog; i++) @(negedge clk);
      model_start();
      check("restart_tog", ntog, m_tog);
      wait_idle();
      check("restart_din", din, m_din);
      check("restart_ovr", overrun, 1'b0);
      check("restart_cks", checksum, 8'h00);
      check("pair_match", mif.mem_req, mif.mem_ack);

      // Foreign index: no memory traffic.
      @(negedge clk); upload = 1'b0;
      repeat (2) @(negedge clk);
      index  = 8'h01;
      upload = 1'b1;
      repeat (10) @(negedge clk);
      check("idx_tog", ntog, m_tog);
      check("idx_busy", busy, 1'b0);
      upload = 1'b0;
      repeat (2) @(negedge clk);

      // Random reads over fresh memory contents.
      for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
      lat = 0;
      model_start();
      up_start(8'h04);
      check("rnd_start_din", din, m_din);
      for (int i = 0; i < 60; i++) begin
         int a;
         lat = $urandom_range(0, 4);
         a = ($urandom_range(0, 9) == 0) ? 'h1FFFF : $urandom_range(0, 7);
         host_rd(a);
      end

      @(negedge clk); upload = 1'b0;
      repeat (3) @(negedge clk);
      check("end_busy", busy, 1'b0);
      check("end_cks_hold", checksum, exp_cks());

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
